// File: rtl/cas_fsk_encoder.sv
// cas_fsk_encoder: turns a CAS file byte stream into the MSX cassette FSK
// waveform. Bytes are gathered into 8-byte blocks, then each byte is sent
// as 11 bits (start 0, data LSB first, two stop 1s). A 0 bit is one slow
// cycle and a 1 bit is two fast cycles, each bit lasting 4*HALF_SHORT ticks.
//
// Optional build macro: CAS_HEADER_DETECT_EN. When defined, a full block
// matching the CAS header pattern is replaced by a 2400 Hz sync tone
// (long after reset/rewind, short afterwards). When undefined, header
// blocks are serialised like any other data.
//
// Ports:
//   clk       system clock
//   reset     synchronous active-high reset
//   ce_5m3    tick enable pacing all waveform timing
//   play      1 = run, 0 = pause (output forced low, everything held)
//   rewind    synchronous restart, same effect as reset
//   in_data   CAS file byte
//   in_valid  in_data is valid
//   in_last   in_data is the final byte of the file
//   in_ready  byte accepted on in_valid & in_ready
//   cas_out   FSK tape signal
//   active    high while a tone or bit is being emitted
module cas_fsk_encoder #(
  parameter int unsigned HALF_SHORT   = 1119,
  parameter int unsigned LONG_CYCLES  = 16000,
  parameter int unsigned SHORT_CYCLES = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_5m3,
  input  logic       play,
  input  logic       rewind,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       cas_out,
  output logic       active
);

  localparam int unsigned TICK_W = $clog2(4 * HALF_SHORT);
  localparam logic [TICK_W-1:0] T_H      = TICK_W'(HALF_SHORT);
  localparam logic [TICK_W-1:0] T_2H     = TICK_W'(2 * HALF_SHORT);
  localparam logic [TICK_W-1:0] T_3H     = TICK_W'(3 * HALF_SHORT);
  localparam logic [TICK_W-1:0] BIT_LAST = TICK_W'(4 * HALF_SHORT - 1);

  // The tone cycle counter is 14 bits wide; larger cycle counts are illegal.
  if (LONG_CYCLES > 16383 || SHORT_CYCLES > 16383 || HALF_SHORT == 0) begin : g_bad_param
    $error("cas_fsk_encoder: illegal parameter value");
  end

  typedef enum logic [2:0] {
    FILL,
    CHECK,
    TONE,
    SEND,
    DONE
  } state_t;

  state_t            state;
  logic [7:0]        buf_q [8];
  logic [3:0]        cnt_q;      // bytes held in the current block (1..8)
  logic              last_q;     // current block ends the file
  logic [2:0]        byte_idx;
  logic [3:0]        bit_idx;    // 0 start, 1..8 data, 9..10 stop
  logic [TICK_W-1:0] tick_q;     // tick within current bit or tone cycle

  logic              accept_c;
  logic              cur_one_c;
  logic [7:0]        cur_byte_c;
  logic [TICK_W-1:0] tick_inc_c;
  logic              bit_end_c;
  logic              last_byte_c;

  assign accept_c    = in_valid & in_ready & play;
  assign cur_byte_c  = buf_q[byte_idx];
  assign tick_inc_c  = tick_q + TICK_W'(1);
  assign bit_end_c   = (tick_q == BIT_LAST);
  assign last_byte_c = ({1'b0, byte_idx} == (cnt_q - 4'd1));

  // Value of the bit currently on the wire.
  always_comb begin
    cur_one_c = 1'b1;
    if (bit_idx == 4'd0) begin
      cur_one_c = 1'b0;
    end else if (bit_idx <= 4'd8) begin
      cur_one_c = cur_byte_c[3'(bit_idx - 4'd1)];
    end
  end

  // Output level at tick t of a bit: a 1 bit (and a tone cycle) toggles every
  // HALF_SHORT ticks, a 0 bit every 2*HALF_SHORT ticks; both start high.
  function automatic logic wave_lvl(input logic one, input logic [TICK_W-1:0] t);
    if (one) begin
      wave_lvl = (t < T_H) || ((t >= T_2H) && (t < T_3H));
    end else begin
      wave_lvl = (t < T_2H);
    end
  endfunction

`ifdef CAS_HEADER_DETECT_EN
  localparam logic [63:0] HDR = 64'h74_7D_13_CC_BA_DE_A6_1F;
  localparam logic [TICK_W-1:0] CYC_LAST = TICK_W'(2 * HALF_SHORT - 1);

  logic        first_hdr;
  logic [13:0] tone_cnt;
  logic [13:0] tone_target_c;
  logic        hdr_match_c;
  logic        cyc_end_c;

  assign tone_target_c = first_hdr ? 14'(LONG_CYCLES) : 14'(SHORT_CYCLES);
  assign cyc_end_c     = (tick_q == CYC_LAST);

  // Only a complete block can be a header.
  always_comb begin
    hdr_match_c = (cnt_q == 4'd8);
    for (int i = 0; i < 8; i++) begin
      if (buf_q[i] != HDR[8*i +: 8]) hdr_match_c = 1'b0;
    end
  end
`endif

  // Block sequencer and waveform generator.
  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      state    <= FILL;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      byte_idx <= '0;
      bit_idx  <= '0;
      tick_q   <= '0;
      cas_out  <= 1'b0;
      active   <= 1'b0;
      in_ready <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
`ifdef CAS_HEADER_DETECT_EN
      first_hdr <= 1'b1;
      tone_cnt  <= '0;
`endif
    end else if (!play) begin
      // Pause: line goes quiet, all positions are frozen.
      cas_out  <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept_c) begin
            buf_q[cnt_q[2:0]] <= in_data;
            cnt_q             <= cnt_q + 4'd1;
            if (cnt_q == 4'd7 || in_last) begin
              state    <= CHECK;
              last_q   <= in_last;
              in_ready <= 1'b0;
            end
          end
        end

        CHECK: begin
          tick_q   <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          cas_out  <= 1'b1;
          active   <= 1'b1;
          state    <= SEND;
`ifdef CAS_HEADER_DETECT_EN
          if (hdr_match_c) begin
            state    <= TONE;
            tone_cnt <= '0;
          end
`endif
        end

        TONE: begin
`ifdef CAS_HEADER_DETECT_EN
          if (!ce_5m3) begin
            cas_out <= wave_lvl(1'b1, tick_q);
          end else if (cyc_end_c) begin
            tick_q <= '0;
            if (tone_cnt == tone_target_c - 14'd1) begin
              state     <= FILL;
              cas_out   <= 1'b0;
              active    <= 1'b0;
              in_ready  <= 1'b1;
              first_hdr <= 1'b0;
              cnt_q     <= '0;
              tone_cnt  <= '0;
            end else begin
              tone_cnt <= tone_cnt + 14'd1;
              cas_out  <= 1'b1;
            end
          end else begin
            tick_q  <= tick_inc_c;
            cas_out <= wave_lvl(1'b1, tick_inc_c);
          end
`else
          state    <= FILL;
          cas_out  <= 1'b0;
          active   <= 1'b0;
          in_ready <= 1'b1;
`endif
        end

        SEND: begin
          if (!ce_5m3) begin
            cas_out <= wave_lvl(cur_one_c, tick_q);
          end else if (bit_end_c) begin
            tick_q <= '0;
            if (bit_idx == 4'd10) begin
              bit_idx <= '0;
              if (last_byte_c) begin
                cas_out  <= 1'b0;
                active   <= 1'b0;
                cnt_q    <= '0;
                byte_idx <= '0;
                if (last_q) begin
                  state <= DONE;
                end else begin
                  state    <= FILL;
                  in_ready <= 1'b1;
                end
              end else begin
                byte_idx <= byte_idx + 3'd1;
                cas_out  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              cas_out <= 1'b1;
            end
          end else begin
            tick_q  <= tick_inc_c;
            cas_out <= wave_lvl(cur_one_c, tick_inc_c);
          end
        end

        DONE: begin
          cas_out  <= 1'b0;
          active   <= 1'b0;
          in_ready <= 1'b0;
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cas_fsk_encoder.sv
// Self-checking bench for cas_fsk_encoder. The expected tape waveform is
// built per tick from the bit/tone shape rules and compared against the
// captured cas_out stream.
module tb_cas_fsk_encoder;

  localparam int unsigned H      = 4;
  localparam int unsigned LONGC  = 6;
  localparam int unsigned SHORTC = 3;
  localparam int unsigned BUDGET = 20000;

  logic       clk = 1'b0;
  logic       reset, ce_5m3, play, rewind;
  logic [7:0] in_data;
  logic       in_valid, in_last;
  logic       in_ready, cas_out, active;

  int n_checks = 0;
  int n_pass   = 0;

  logic exp_q[$];
  logic smp_q[$];
  logic ply_q[$];
  logic rdy_q[$];
  logic mon_p;

  logic [7:0] hdr [8];

  always #5 clk = ~clk;

  cas_fsk_encoder #(
    .HALF_SHORT  (H),
    .LONG_CYCLES (LONGC),
    .SHORT_CYCLES(SHORTC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ce_5m3  (ce_5m3),
    .play    (play),
    .rewind  (rewind),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .cas_out (cas_out),
    .active  (active)
  );

  // Capture every emitted sample together with the play level at that edge.
  always @(posedge clk) begin
    mon_p = play;
    #1;
    if (active === 1'b1) begin
      smp_q.push_back(cas_out);
      ply_q.push_back(mon_p);
      rdy_q.push_back(in_ready);
    end
  end

  // ---------------- reference model ----------------
  function automatic void m_bit(input logic b);
    if (!b) begin
      repeat (2*H) exp_q.push_back(1'b1);
      repeat (2*H) exp_q.push_back(1'b0);
    end else begin
      repeat (2) begin
        repeat (H) exp_q.push_back(1'b1);
        repeat (H) exp_q.push_back(1'b0);
      end
    end
  endfunction

  function automatic void m_byte(input logic [7:0] d);
    m_bit(1'b0);
    for (int i = 0; i < 8; i++) m_bit(d[i]);
    m_bit(1'b1);
    m_bit(1'b1);
  endfunction

  function automatic void m_tone(input int n);
    repeat (n) begin
      repeat (H) exp_q.push_back(1'b1);
      repeat (H) exp_q.push_back(1'b0);
    end
  endfunction

  // Index of the first captured sample that disagrees with the model, or -1.
  // Paused samples must be low with in_ready low and consume no model tick.
  function automatic int first_diff();
    int k;
    k = 0;
    foreach (smp_q[i]) begin
      if (ply_q[i] === 1'b0) begin
        if (smp_q[i] !== 1'b0 || rdy_q[i] !== 1'b0) return i;
      end else begin
        if (k >= exp_q.size()) return i;
        if (smp_q[i] !== exp_q[k]) return i;
        k++;
      end
    end
    if (k != exp_q.size()) return smp_q.size();
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_cap();
    exp_q.delete();
    smp_q.delete();
    ply_q.delete();
    rdy_q.delete();
  endtask

  task automatic do_reset(input logic use_rewind);
    in_valid = 1'b0;
    in_last  = 1'b0;
    play     = 1'b1;
    if (use_rewind) rewind = 1'b1; else reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    rewind = 1'b0;
    @(negedge clk);
    clear_cap();
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      n_checks++;
      $display("FAIL push_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_quiet(input logic want_rdy);
    int n, q;
    n = 0;
    q = 0;
    while (q < 3 && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (active === 1'b0 && in_ready === want_rdy) q++; else q = 0;
    end
    if (q < 3) begin
      n_checks++;
      $display("FAIL quiet_timeout: active=%b in_ready=%b, required 0/%b", active, in_ready, want_rdy);
    end
  endtask

  task automatic wait_samples(input int target);
    int n;
    n = 0;
    while (smp_q.size() < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      n_checks++;
      $display("FAIL sample_timeout: got %0d samples, required %0d", smp_q.size(), target);
    end
  endtask

  task automatic push_header(input logic last_on_8th);
    for (int i = 0; i < 8; i++) push_byte(hdr[i], (i == 7) ? last_on_8th : 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int d;
    reset    = 1'b1;
    rewind   = 1'b0;
    play     = 1'b1;
    ce_5m3   = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cas_out !== 1'b0) $display("FAIL rst_cas_out: got %b want 0", cas_out); else n_pass++;
    n_checks++;
    if (active !== 1'b0) $display("FAIL rst_active: got %b want 0", active); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_pass++;

    // reset and rewind together mid-stream behave as a plain reset
    clear_cap();
    push_byte(8'($urandom), 1'b1);
    wait_samples(30);
    reset  = 1'b1;
    rewind = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cas_out !== 1'b0 || active !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rst_rew_both: cas/act/rdy=%b%b%b want 000", cas_out, active, in_ready);
    else n_pass++;
    reset  = 1'b0;
    rewind = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_rew_ready: got %b want 1", in_ready); else n_pass++;
    clear_cap();
    m_byte(8'h5A);
    push_byte(8'h5A, 1'b1);
    wait_quiet(1'b0);
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL rst_rew_stream: first diff at sample %0d, want none", d); else n_pass++;
  endtask

  task automatic test_single_zero();
    int d;
    do_reset(1'b0);
    m_byte(8'h00);
    push_byte(8'h00, 1'b1);
    wait_quiet(1'b0);
    n_checks++;
    if (smp_q.size() !== 176) $display("FAIL zero_len: got %0d ticks want 176", smp_q.size()); else n_pass++;
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL zero_stream: first diff at sample %0d, want none", d); else n_pass++;
    // DONE holds and refuses input
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (active !== 1'b0 || in_ready !== 1'b0 || cas_out !== 1'b0)
      $display("FAIL done_hold: act/rdy/cas=%b%b%b want 000", active, in_ready, cas_out);
    else n_pass++;
    n_checks++;
    if (smp_q.size() !== 176) $display("FAIL done_no_emit: got %0d ticks want 176", smp_q.size()); else n_pass++;
  endtask

  task automatic test_random_file();
    int n, d;
    logic [7:0] b;
    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0);
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        m_byte(b);
        push_byte(b, (i == n - 1));
      end
      wait_quiet(1'b0);
      n_checks++;
      if (smp_q.size() !== n * 176)
        $display("FAIL rand_len[%0d]: got %0d ticks want %0d", t, smp_q.size(), n * 176);
      else n_pass++;
      d = first_diff();
      n_checks++;
      if (d !== -1) $display("FAIL rand_stream[%0d]: first diff at sample %0d, want none", t, d); else n_pass++;
    end
  endtask

  task automatic test_pause();
    int d, paused;
    logic [7:0] b;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      m_byte(b);
      push_byte(b, (i == 2));
    end
    wait_samples($urandom_range(5, 500));
    play = 1'b0;
    repeat (20) @(negedge clk);
    play = 1'b1;
    wait_quiet(1'b0);
    paused = 0;
    foreach (ply_q[i]) if (ply_q[i] === 1'b0) paused++;
    n_checks++;
    if (paused !== 20) $display("FAIL pause_len: got %0d paused clks want 20", paused); else n_pass++;
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL pause_stream: first diff at sample %0d, want none", d); else n_pass++;
  endtask

  task automatic test_no_accept_paused();
    int d;
    do_reset(1'b0);
    play     = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    in_last  = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || active !== 1'b0)
      $display("FAIL paused_ready: rdy/act=%b%b want 00", in_ready, active);
    else n_pass++;
    play = 1'b1;
    m_byte(8'hC3);
    push_byte(8'hC3, 1'b1);
    wait_quiet(1'b0);
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL paused_accept: first diff at sample %0d, want none", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d;
    logic [7:0] b;
    // rewind out of DONE, then a second file
    rewind = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL rewind_ready0: got %b want 0", in_ready); else n_pass++;
    rewind = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rewind_ready1: got %b want 1", in_ready); else n_pass++;
    clear_cap();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      m_byte(b);
      push_byte(b, (i == 9));
    end
    wait_quiet(1'b0);
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL b2b_stream: first diff at sample %0d, want none", d); else n_pass++;
  endtask

`ifdef CAS_HEADER_DETECT_EN
  task automatic test_header();
    int d;
    do_reset(1'b0);
    m_tone(LONGC);
    m_byte(8'hFF);
    push_header(1'b0);
    push_byte(8'hFF, 1'b1);
    wait_quiet(1'b0);
    n_checks++;
    if (smp_q.size() !== 48 + 176) $display("FAIL hdr_len: got %0d want 224", smp_q.size()); else n_pass++;
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL hdr_stream: first diff at sample %0d, want none", d); else n_pass++;

    do_reset(1'b0);
    m_tone(LONGC);
    m_tone(SHORTC);
    push_header(1'b0);
    push_header(1'b0);
    wait_quiet(1'b1);
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL hdr_two: first diff at sample %0d, want none", d); else n_pass++;

    do_reset(1'b1);
    m_tone(LONGC);
    push_header(1'b0);
    wait_quiet(1'b1);
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL hdr_rewind: first diff at sample %0d, want none", d); else n_pass++;
  endtask
`else
  task automatic test_header();
    int d;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) m_byte(hdr[i]);
    push_header(1'b1);
    wait_quiet(1'b0);
    n_checks++;
    if (smp_q.size() !== 88 * 16) $display("FAIL hdr_data_len: got %0d want 1408", smp_q.size()); else n_pass++;
    d = first_diff();
    n_checks++;
    if (d !== -1) $display("FAIL hdr_data_stream: first diff at sample %0d, want none", d); else n_pass++;
  endtask
`endif

  task automatic test_reset_midstream();
    do_reset(1'b0);
`ifdef CAS_HEADER_DETECT_EN
    push_header(1'b0);
    wait_samples(2 * H + 3);
`else
    push_byte(8'($urandom), 1'b1);
    wait_samples(4 * H + 3);
`endif
    n_checks++;
    if (active !== 1'b1) $display("FAIL mid_active: got %b want 1", active); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cas_out !== 1'b0 || active !== 1'b0)
      $display("FAIL mid_abort: cas/act=%b%b want 00", cas_out, active);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || cas_out !== 1'b0)
      $display("FAIL mid_ready: rdy/cas=%b%b want 10", in_ready, cas_out);
    else n_pass++;
  endtask

  initial begin
    hdr[0] = 8'h1F; hdr[1] = 8'hA6; hdr[2] = 8'hDE; hdr[3] = 8'hBA;
    hdr[4] = 8'hCC; hdr[5] = 8'h13; hdr[6] = 8'h7D; hdr[7] = 8'h74;
    test_reset();
    test_single_zero();
    test_back_to_back();
    test_random_file();
    test_pause();
    test_no_accept_paused();
    test_header();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
